instr_fetch_unit: RTL

// - Front end of the mini CPU; produces the opcode stream that the decode/control logic consumes.
// - Fetches 16-bit instructions from instruction memory over a request/response interface.
// - Holds each instruction in an instruction register, then presents it to decode with a valid/ready handshake.
// - Applies PC redirects (JMP) issued by the execute side and squashes any in-flight fetch.

---
 rtl/cpu_pkg.sv | 41 ++++
 rtl/fetch_ir_reg.sv | 55 +++++
 rtl/instr_fetch_unit.sv | 114 +++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the mini CPU front end: widths, instruction field
// positions, opcode values and the fetch FSM state encoding.
// No logic lives here; latency and backpressure are properties of the users.
package cpu_pkg;

  localparam int PC_W    = 8;
  localparam int INSTR_W = 16;
  localparam int OPC_W   = 4;
  localparam int RD_W    = 4;
  localparam int IMM_W   = 8;

  // Instruction layout: [15:12] opcode, [11:8] rd, [7:0] imm/addr
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 8;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  localparam logic [OPC_W-1:0] OP_LDI = 4'd1;
  localparam logic [OPC_W-1:0] OP_ADD = 4'd2;
  localparam logic [OPC_W-1:0] OP_SUB = 4'd3;
  localparam logic [OPC_W-1:0] OP_XOR = 4'd4;
  localparam logic [OPC_W-1:0] OP_LD  = 4'd5;
  localparam logic [OPC_W-1:0] OP_ST  = 4'd6;
  localparam logic [OPC_W-1:0] OP_JMP = 4'd7;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DRAIN = 3'd4
  } fetch_state_e;

  // Sequential fetch address; wraps naturally at 2^PC_W.
  function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] cur);
    return cur + 1'b1;
  endfunction

endpackage

// File: rtl/fetch_ir_reg.sv
// Instruction register plus valid bit; priority squash > load > consume.
// Latency: loaded word visible the cycle after load_i.
// Backpressure: contents held unchanged until consume_i or squash_i.
// Ports: clk/rst; load_i with load_instr_i/load_pc_i; consume_i; squash_i;
//        valid_o, instr_o, pc_o (all registered).
module fetch_ir_reg import cpu_pkg::*; (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic               consume_i,
  input  logic               squash_i,
  input  logic [INSTR_W-1:0] load_instr_i,
  input  logic [PC_W-1:0]    load_pc_i,
  output logic               valid_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic [PC_W-1:0]    pc_o
);

  logic               valid_q, valid_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]    pc_q, pc_d;

  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (squash_i) begin
      // Only the valid bit drops; stale data is harmless once invalid.
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      instr_d = load_instr_i;
      pc_d    = load_pc_i;
    end else if (consume_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: PC, fetch FSM, one outstanding imem request.
// Latency: 1 cycle REQ + memory latency + 1 cycle HOLD; 3 cycles/instr at 1-cycle memory.
// Backpressure: instruction held stable while instr_ready=0, no new fetch issued.
// Ports: clk, rst (sync, active high), run; imem_req/imem_addr out and
//        imem_rvalid/imem_rdata in; instr_valid/instr_ready handshake with
//        opcode/rd/imm/instr_pc; redirect_valid/redirect_pc; pc status.
module instr_fetch_unit import cpu_pkg::*; (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [OPC_W-1:0]   opcode,
  output logic [RD_W-1:0]    rd,
  output logic [IMM_W-1:0]   imm,
  output logic [PC_W-1:0]    instr_pc,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic [PC_W-1:0]    pc
);

  fetch_state_e       state_q, state_d, fetch_next;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [PC_W-1:0]    addr_q, addr_d;
  logic               req_q, req_d;
  logic               ir_load, ir_consume, ir_squash;
  logic               ir_valid;
  logic [INSTR_W-1:0] ir_instr;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_load    = 1'b0;
    ir_consume = 1'b0;
    ir_squash  = 1'b0;
    fetch_next = run ? ST_REQ : ST_IDLE;

    if (redirect_valid) begin
      pc_d      = redirect_pc;
      ir_squash = 1'b1;
      unique case (state_q)
        // The request pulsing this cycle is already on its way to memory,
        // so its response must be drained before refetching.
        ST_REQ:            state_d = ST_DRAIN;
        ST_WAIT, ST_DRAIN: state_d = imem_rvalid ? fetch_next : ST_DRAIN;
        default:           state_d = fetch_next;
      endcase
    end else begin
      unique case (state_q)
        ST_IDLE: if (run) state_d = ST_REQ;
        ST_REQ:  state_d = ST_WAIT;
        ST_WAIT: begin
          if (imem_rvalid) begin
            ir_load = 1'b1;
            pc_d    = pc_inc(pc_q);
            state_d = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (ir_valid && instr_ready) begin
            ir_consume = 1'b1;
            state_d    = fetch_next;
          end
        end
        ST_DRAIN: if (imem_rvalid) state_d = fetch_next;
        default:  state_d = ST_IDLE;
      endcase
    end

    // Request and address are flopped so imem_req has no path from inputs.
    req_d  = (state_d == ST_REQ);
    addr_d = req_d ? pc_d : addr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      req_q   <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
    end
  end

  fetch_ir_reg u_ir (
    .clk          (clk),
    .rst          (rst),
    .load_i       (ir_load),
    .consume_i    (ir_consume),
    .squash_i     (ir_squash),
    .load_instr_i (imem_rdata),
    .load_pc_i    (pc_q),
    .valid_o      (ir_valid),
    .instr_o      (ir_instr),
    .pc_o         (instr_pc)
  );

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign pc          = pc_q;
  assign instr_valid = ir_valid;
  assign opcode      = ir_instr[OPC_MSB:OPC_LSB];
  assign rd          = ir_instr[RD_MSB:RD_LSB];
  assign imm         = ir_instr[IMM_MSB:IMM_LSB];

endmodule
